// File: rtl/id_ex_stage_register_if.sv
// ID/EX stage bundle: ID-side operands and control in, EX-side fields,
// stall request and debug counters out. The master drives the ID side and
// pipeline control; the slave is the stage register itself.
interface id_ex_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 8,
  parameter int CNT_W      = 16
);
  // pipeline control
  logic                  enable;
  logic                  flush;
  logic                  cnt_clr;
  // decode stage
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [CTRL_W-1:0]     id_ctrl;
  logic [DATA_W-1:0]     id_rs1_data;
  logic [DATA_W-1:0]     id_rs2_data;
  logic [DATA_W-1:0]     id_imm;
  logic [DATA_W-1:0]     id_pc;
  // execute stage and status
  logic                  stall;
  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [CTRL_W-1:0]     ex_ctrl;
  logic [DATA_W-1:0]     ex_rs1_data;
  logic [DATA_W-1:0]     ex_rs2_data;
  logic [DATA_W-1:0]     ex_imm;
  logic [DATA_W-1:0]     ex_pc;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output enable, flush, cnt_clr,
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_ctrl,
    output id_rs1_data, id_rs2_data, id_imm, id_pc,
    input  stall, ex_valid, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
    input  ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, stall_cnt, flush_cnt
  );

  modport slave (
    input  enable, flush, cnt_clr,
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_ctrl,
    input  id_rs1_data, id_rs2_data, id_imm, id_pc,
    output stall, ex_valid, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
    output ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with load-use hazard detection. A load in EX whose
// destination is read by the instruction in ID causes a one-cycle bubble and a
// combinational stall request; a branch flush squashes ID. Saturating counters
// record how many of each kind of bubble were inserted.
module id_ex_stage_register #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 8,
  parameter int CNT_W      = 16
) (
  input logic    clk,
  input logic    reset_n,
  id_ex_if.slave bus
);
  localparam int CTRL_MEM_READ = 1;

  logic                  ex_valid_reg;
  logic [REG_ADDR_W-1:0] ex_rs1_reg;
  logic [REG_ADDR_W-1:0] ex_rs2_reg;
  logic [REG_ADDR_W-1:0] ex_rd_reg;
  logic [CTRL_W-1:0]     ex_ctrl_reg;
  logic [DATA_W-1:0]     ex_rs1_data_reg;
  logic [DATA_W-1:0]     ex_rs2_data_reg;
  logic [DATA_W-1:0]     ex_imm_reg;
  logic [DATA_W-1:0]     ex_pc_reg;
  logic [CNT_W-1:0]      stall_cnt_reg;
  logic [CNT_W-1:0]      flush_cnt_reg;

  logic hazard;
  logic bubble;

  // Load in EX writing a nonzero register that the ID instruction actually reads.
  always_comb begin
    hazard = ex_valid_reg && ex_ctrl_reg[CTRL_MEM_READ] && (ex_rd_reg != '0) && bus.id_valid &&
             ((bus.id_rs1_used && (bus.id_rs1 == ex_rd_reg)) ||
              (bus.id_rs2_used && (bus.id_rs2 == ex_rd_reg)));
    bubble = bus.flush || hazard;
  end

  // A flush replaces the held instruction anyway, so no freeze is needed then.
  assign bus.stall = hazard && !bus.flush;

  // Stage register: bubble on flush or hazard, otherwise capture the ID fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_reg    <= 1'b0;
      ex_rs1_reg      <= '0;
      ex_rs2_reg      <= '0;
      ex_rd_reg       <= '0;
      ex_ctrl_reg     <= '0;
      ex_rs1_data_reg <= '0;
      ex_rs2_data_reg <= '0;
      ex_imm_reg      <= '0;
      ex_pc_reg       <= '0;
    end else if (bus.enable) begin
      if (bubble) begin
        // zero indices so the forwarding unit can never match a bubble
        ex_valid_reg    <= 1'b0;
        ex_rs1_reg      <= '0;
        ex_rs2_reg      <= '0;
        ex_rd_reg       <= '0;
        ex_ctrl_reg     <= '0;
        ex_rs1_data_reg <= '0;
        ex_rs2_data_reg <= '0;
        ex_imm_reg      <= '0;
        ex_pc_reg       <= '0;
      end else begin
        ex_valid_reg    <= bus.id_valid;
        ex_rs1_reg      <= bus.id_rs1;
        ex_rs2_reg      <= bus.id_rs2;
        ex_rd_reg       <= bus.id_rd;
        ex_ctrl_reg     <= bus.id_ctrl;
        ex_rs1_data_reg <= bus.id_rs1_data;
        ex_rs2_data_reg <= bus.id_rs2_data;
        ex_imm_reg      <= bus.id_imm;
        ex_pc_reg       <= bus.id_pc;
      end
    end
  end

  // Saturating bubble counters; clear works even while the pipeline is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (bus.cnt_clr) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (bus.enable) begin
      if (bus.flush) begin
        if (flush_cnt_reg != '1) flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end else if (hazard) begin
        if (stall_cnt_reg != '1) stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign bus.ex_valid    = ex_valid_reg;
  assign bus.ex_rs1      = ex_rs1_reg;
  assign bus.ex_rs2      = ex_rs2_reg;
  assign bus.ex_rd       = ex_rd_reg;
  assign bus.ex_ctrl     = ex_ctrl_reg;
  assign bus.ex_rs1_data = ex_rs1_data_reg;
  assign bus.ex_rs2_data = ex_rs2_data_reg;
  assign bus.ex_imm      = ex_imm_reg;
  assign bus.ex_pc       = ex_pc_reg;
  assign bus.stall_cnt   = stall_cnt_reg;
  assign bus.flush_cnt   = flush_cnt_reg;
endmodule

// File: tb/tb_id_ex_stage_register.sv
// Directed bench for the ID/EX stage register. Counters are built 8 bits wide
// here so that saturation can be reached in a few hundred cycles.
module tb_id_ex_stage_register;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 8;
  localparam int CNT_W      = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CTRL_W-1:0] CTRL_LW  = 8'h0B; // reg_write|mem_read|mem_to_reg
  localparam logic [CTRL_W-1:0] CTRL_ADD = 8'h01; // reg_write

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  id_ex_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage_register #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge; outputs are sampled 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic rs1_u, input logic rs2_u, input logic [4:0] rd,
                        input logic [7:0] ctrl, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [31:0] pc);
    bus.id_valid    = v;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rs1_used = rs1_u;
    bus.id_rs2_used = rs2_u;
    bus.id_rd       = rd;
    bus.id_ctrl     = ctrl;
    bus.id_rs1_data = d1;
    bus.id_rs2_data = d2;
    bus.id_imm      = imm;
    bus.id_pc       = pc;
  endtask

  task automatic clear_counters();
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    // capture something nonzero, then reset mid-cycle with no edge
    set_id(1'b1, 5'd7, 5'd8, 1'b1, 1'b1, 5'd9, 8'hF5, 32'hAAAA_0001, 32'hBBBB_0002, 32'h1234, 32'h400);
    bus.enable = 1'b1;
    tick();
    vectors++;
    if (bus.ex_rd !== 5'd9) begin
      miscompares++; $display("FAIL reset_precapture_rd: got %0d want 9", bus.ex_rd);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.ex_valid, bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_ctrl} !== '0) begin
      miscompares++; $display("FAIL reset_ctrl_fields: got v=%0b rs1=%0d rs2=%0d rd=%0d ctrl=%h want all 0",
                              bus.ex_valid, bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_ctrl);
    end
    vectors++;
    if ({bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm, bus.ex_pc} !== '0) begin
      miscompares++; $display("FAIL reset_data_fields: got %h %h %h %h want 0",
                              bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm, bus.ex_pc);
    end
    vectors++;
    if ({bus.stall, bus.stall_cnt, bus.flush_cnt} !== '0) begin
      miscompares++; $display("FAIL reset_status: got stall=%0b scnt=%0d fcnt=%0d want 0",
                              bus.stall, bus.stall_cnt, bus.flush_cnt);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_pass_through();
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 8'h11, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h10, 32'h100);
    tick();
    vectors++;
    if ({bus.ex_valid, bus.ex_rs1, bus.ex_rs2, bus.ex_rd} !== {1'b1, 5'd3, 5'd4, 5'd5}) begin
      miscompares++; $display("FAIL pass_indices: got v=%0b rs1=%0d rs2=%0d rd=%0d want 1/3/4/5",
                              bus.ex_valid, bus.ex_rs1, bus.ex_rs2, bus.ex_rd);
    end
    vectors++;
    if (bus.ex_ctrl !== 8'h11) begin
      miscompares++; $display("FAIL pass_ctrl: got %h want 11", bus.ex_ctrl);
    end
    vectors++;
    if ({bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm, bus.ex_pc} !==
        {32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h10, 32'h100}) begin
      miscompares++; $display("FAIL pass_data: got %h %h %h %h want deadbeef 0badf00d 10 100",
                              bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm, bus.ex_pc);
    end
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL pass_stall: got %0b want 0", bus.stall);
    end
  endtask

  task automatic test_load_use();
    clear_counters();
    set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, CTRL_LW, 32'h1, 32'h0, 32'h8, 32'h200);
    tick();
    set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, CTRL_ADD, 32'h11, 32'h22, 32'h0, 32'h204);
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin
      miscompares++; $display("FAIL lu_stall_asserted: got %0b want 1", bus.stall);
    end
    tick();
    vectors++;
    if ({bus.ex_valid, bus.ex_ctrl, bus.ex_rd, bus.ex_rs1, bus.ex_pc} !== '0) begin
      miscompares++; $display("FAIL lu_bubble: got v=%0b ctrl=%h rd=%0d rs1=%0d pc=%h want 0",
                              bus.ex_valid, bus.ex_ctrl, bus.ex_rd, bus.ex_rs1, bus.ex_pc);
    end
    vectors++;
    if (bus.stall_cnt !== 8'd1 || bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL lu_count_one_cycle: got scnt=%0d stall=%0b want 1/0",
                              bus.stall_cnt, bus.stall);
    end
    tick();
    vectors++;
    if ({bus.ex_valid, bus.ex_rs1, bus.ex_rd, bus.ex_pc} !== {1'b1, 5'd5, 5'd6, 32'h204}) begin
      miscompares++; $display("FAIL lu_capture_after: got v=%0b rs1=%0d rd=%0d pc=%h want 1/5/6/204",
                              bus.ex_valid, bus.ex_rs1, bus.ex_rd, bus.ex_pc);
    end
    vectors++;
    if (bus.stall_cnt !== 8'd1) begin
      miscompares++; $display("FAIL lu_count_hold: got %0d want 1", bus.stall_cnt);
    end
  endtask

  task automatic test_flush_priority();
    clear_counters();
    set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, CTRL_LW, 32'h1, 32'h0, 32'h8, 32'h300);
    tick();
    set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, CTRL_ADD, 32'h11, 32'h22, 32'h0, 32'h304);
    bus.flush = 1'b1;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL fl_stall_masked: got %0b want 0", bus.stall);
    end
    tick();
    bus.flush = 1'b0;
    vectors++;
    if ({bus.ex_valid, bus.ex_rd, bus.ex_ctrl} !== '0) begin
      miscompares++; $display("FAIL fl_bubble: got v=%0b rd=%0d ctrl=%h want 0",
                              bus.ex_valid, bus.ex_rd, bus.ex_ctrl);
    end
    vectors++;
    if (bus.flush_cnt !== 8'd1 || bus.stall_cnt !== 8'd0) begin
      miscompares++; $display("FAIL fl_counts: got fcnt=%0d scnt=%0d want 1/0",
                              bus.flush_cnt, bus.stall_cnt);
    end
  endtask

  task automatic test_no_false_hazard();
    clear_counters();
    // load targeting x0 never stalls
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, CTRL_LW, 32'h0, 32'h0, 32'h0, 32'h400);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, CTRL_ADD, 32'h0, 32'h0, 32'h0, 32'h404);
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL nf_rd_zero: got stall %0b want 0", bus.stall);
    end
    // load to x5, ID names rs2=5 but does not read it
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, CTRL_LW, 32'h0, 32'h0, 32'h0, 32'h408);
    tick();
    set_id(1'b1, 5'd1, 5'd5, 1'b1, 1'b0, 5'd6, CTRL_ADD, 32'h0, 32'h0, 32'h0, 32'h40C);
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL nf_rs2_unused: got stall %0b want 0", bus.stall);
    end
    // now make it a real hazard, but hold the pipeline for 3 cycles
    bus.id_rs2_used = 1'b1;
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({bus.stall, bus.ex_valid, bus.ex_rd, bus.ex_pc, bus.stall_cnt} !==
          {1'b1, 1'b1, 5'd5, 32'h408, 8'd0}) begin
        miscompares++; $display("FAIL nf_hold_%0d: got stall=%0b v=%0b rd=%0d pc=%h scnt=%0d want 1/1/5/408/0",
                                i, bus.stall, bus.ex_valid, bus.ex_rd, bus.ex_pc, bus.stall_cnt);
      end
    end
    bus.enable = 1'b1;
    tick();
    vectors++;
    if (bus.ex_valid !== 1'b0 || bus.stall_cnt !== 8'd1) begin
      miscompares++; $display("FAIL nf_release_bubble: got v=%0b scnt=%0d want 0/1",
                              bus.ex_valid, bus.stall_cnt);
    end
    tick();
  endtask

  task automatic test_saturation();
    clear_counters();
    for (int i = 0; i < int'(CNT_MAX); i++) begin
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, CTRL_LW, 32'h0, 32'h0, 32'h0, 32'h500);
      tick();
      set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, CTRL_ADD, 32'h0, 32'h0, 32'h0, 32'h504);
      tick();
    end
    vectors++;
    if (bus.stall_cnt !== CNT_MAX) begin
      miscompares++; $display("FAIL sat_stall_reach: got %0d want %0d", bus.stall_cnt, CNT_MAX);
    end
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, CTRL_LW, 32'h0, 32'h0, 32'h0, 32'h500);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, CTRL_ADD, 32'h0, 32'h0, 32'h0, 32'h504);
    tick();
    vectors++;
    if (bus.stall_cnt !== CNT_MAX) begin
      miscompares++; $display("FAIL sat_stall_hold: got %0d want %0d", bus.stall_cnt, CNT_MAX);
    end
    bus.flush = 1'b1;
    for (int i = 0; i < int'(CNT_MAX) + 2; i++) tick();
    bus.flush = 1'b0;
    vectors++;
    if (bus.flush_cnt !== CNT_MAX) begin
      miscompares++; $display("FAIL sat_flush: got %0d want %0d", bus.flush_cnt, CNT_MAX);
    end
    // clear is honoured while the pipeline is held
    bus.enable = 1'b0;
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    bus.enable = 1'b1;
    vectors++;
    if (bus.stall_cnt !== 8'd0 || bus.flush_cnt !== 8'd0) begin
      miscompares++; $display("FAIL sat_clear: got scnt=%0d fcnt=%0d want 0/0",
                              bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, CTRL_LW, 32'h0, 32'h0, 32'h0, 32'h600);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, CTRL_ADD, 32'h0, 32'h0, 32'h0, 32'h604);
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin
      miscompares++; $display("FAIL rms_stall_before: got %0b want 1", bus.stall);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.stall !== 1'b0 || bus.ex_valid !== 1'b0 || bus.ex_rd !== 5'd0) begin
      miscompares++; $display("FAIL rms_cleared: got stall=%0b v=%0b rd=%0d want 0/0/0",
                              bus.stall, bus.ex_valid, bus.ex_rd);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    vectors++;
    if ({bus.ex_valid, bus.ex_rd, bus.ex_pc, bus.stall} !== {1'b1, 5'd6, 32'h604, 1'b0}) begin
      miscompares++; $display("FAIL rms_capture_after: got v=%0b rd=%0d pc=%h stall=%0b want 1/6/604/0",
                              bus.ex_valid, bus.ex_rd, bus.ex_pc, bus.stall);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    bus.enable  = 1'b0;
    bus.flush   = 1'b0;
    bus.cnt_clr = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    test_reset();
    test_pass_through();
    test_load_use();
    test_flush_priority();
    test_no_false_hazard();
    test_saturation();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
